// File: rtl/trdemu_nmi_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : trdemu_nmi_sched_pkg
// Brief  : Shared trdemu constants, FSM encoding and trap record type.
// Rev    : 1.0  initial release
// ============================================================================
package trdemu_nmi_sched_pkg;

    localparam int c_CNT_W           = 12;
    localparam int c_NMI_TIMEOUT_DEF = 4095;
    localparam int c_HOLDOFF_DEF     = 15;

    // NMI scheduler state encoding, also decoded by the trdemu status logic
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_SERVICE = 2'd2;
    localparam logic [1:0] c_ST_HOLDOFF = 2'd3;

    typedef struct packed {
        logic [1:0] vg_a;
        logic       wr;
    } trap_t;

endpackage
`default_nettype wire

// File: rtl/trdemu_trap_slot.sv
`default_nettype none
// ============================================================================
// Module : trdemu_trap_slot
// Brief  : One-deep pending trap slot with sticky overrun flag.
// Rev    : 1.0  initial release
// ============================================================================
module trdemu_trap_slot
    import trdemu_nmi_sched_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_fill,
    input  trap_t i_fill_trap,
    input  logic  i_take,
    input  logic  i_flush,
    input  logic  i_ovr_clr,
    output logic  o_full,
    output trap_t o_trap,
    output logic  o_overrun
);

    logic  r_full;
    trap_t r_trap;
    logic  r_overrun;
    logic  w_accept;
    logic  w_drop;

    // A take in the same cycle frees the slot, so a simultaneous fill refills it
    assign w_accept = i_fill && (!r_full || i_take);
    assign w_drop   = i_fill && r_full && !i_take && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_trap <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_trap <= i_fill_trap;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    // A new loss wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_full    = r_full;
    assign o_trap    = r_trap;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/trdemu_nmi_sched.sv
`default_nettype none
// ============================================================================
// Module : trdemu_nmi_sched
// Brief  : Schedules Z80 NMIs for trapped VG93 accesses in TR-DOS emulation.
// Rev    : 1.0  initial release
// ============================================================================
module trdemu_nmi_sched
    import trdemu_nmi_sched_pkg::*;
#(
    parameter int NMI_TIMEOUT = c_NMI_TIMEOUT_DEF,
    parameter int HOLDOFF     = c_HOLDOFF_DEF
)(
    input  logic       fclk,
    input  logic       rst,
    input  logic       trdemu_en,
    input  logic       trap_req,
    input  logic [1:0] trap_vg_a,
    input  logic       trap_wr,
    input  logic       nmi_fetch,
    input  logic       clr_nmi,
    input  logic       ovr_clr,
    output logic       gen_nmi,
    output logic       in_nmi,
    output logic [1:0] trap_vg_q,
    output logic       trap_wr_q,
    output logic       pend,
    output logic       overrun,
    output logic       timeout_err
);

    localparam logic [c_CNT_W-1:0] c_TMO_CNT = c_CNT_W'(NMI_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_HO_CNT  = c_CNT_W'(HOLDOFF);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    trap_t              r_trap_q;
    logic               r_gen_nmi;
    logic               r_in_nmi;
    logic               r_timeout_err;
    logic               w_gen_nmi_nxt;
    logic               w_in_nmi_nxt;

    logic               w_acc;
    logic               w_tmo_hit;
    logic               w_ho_hit;
    logic               w_take;
    logic               w_load_in;
    logic               w_flush;
    logic               w_tmo_set;
    logic               w_fetch_ok;
    logic               w_fill;
    trap_t              w_in_trap;
    trap_t              w_slot_trap;
    logic               w_slot_full;
    logic               w_slot_ovr;

    assign w_acc     = trap_req && trdemu_en;
    assign w_tmo_hit = (r_cnt == c_TMO_CNT);
    assign w_ho_hit  = (r_cnt == c_HO_CNT);
    assign w_in_trap = '{vg_a: trap_vg_a, wr: trap_wr};

    // Traps seen while busy go to the slot, unless loaded directly or discarded
    assign w_fill = w_acc && (r_state != c_ST_IDLE) && !w_load_in && !w_flush;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == c_ST_REQ || r_state == c_ST_HOLDOFF) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_load_in   = 1'b0;
        w_flush     = 1'b0;
        w_tmo_set   = 1'b0;
        w_fetch_ok  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = c_ST_REQ;
                    w_load_in   = 1'b1;
                end
            end
            c_ST_REQ: begin
                // Fetch is checked first so it wins over a same-cycle timeout
                if (nmi_fetch) begin
                    w_state_nxt = c_ST_SERVICE;
                    w_fetch_ok  = 1'b1;
                end else if (!trdemu_en) begin
                    w_state_nxt = c_ST_IDLE;
                    w_flush     = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_ST_IDLE;
                    w_flush     = 1'b1;
                    w_tmo_set   = 1'b1;
                end
            end
            c_ST_SERVICE: begin
                if (clr_nmi) begin
                    w_state_nxt = c_ST_HOLDOFF;
                end
            end
            c_ST_HOLDOFF: begin
                if (w_ho_hit) begin
                    if (w_slot_full && trdemu_en) begin
                        w_state_nxt = c_ST_REQ;
                        w_take      = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = c_ST_REQ;
                        w_load_in   = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_flush     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_gen_nmi_nxt = (w_state_nxt == c_ST_REQ);
        w_in_nmi_nxt  = (w_state_nxt == c_ST_SERVICE);
    end

    // Outputs are flopped from the next state so no input reaches a port combinationally
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_gen_nmi <= 1'b0;
            r_in_nmi  <= 1'b0;
        end else begin
            r_gen_nmi <= w_gen_nmi_nxt;
            r_in_nmi  <= w_in_nmi_nxt;
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_trap_q <= '0;
        end else if (w_take) begin
            r_trap_q <= w_slot_trap;
        end else if (w_load_in) begin
            r_trap_q <= w_in_trap;
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_fetch_ok) begin
            r_timeout_err <= 1'b0;
        end else if (w_tmo_set) begin
            r_timeout_err <= 1'b1;
        end
    end

    trdemu_trap_slot u_slot (
        .clk         (fclk),
        .rst         (rst),
        .i_fill      (w_fill),
        .i_fill_trap (w_in_trap),
        .i_take      (w_take),
        .i_flush     (w_flush),
        .i_ovr_clr   (ovr_clr),
        .o_full      (w_slot_full),
        .o_trap      (w_slot_trap),
        .o_overrun   (w_slot_ovr)
    );

    assign gen_nmi     = r_gen_nmi;
    assign in_nmi      = r_in_nmi;
    assign trap_vg_q   = r_trap_q.vg_a;
    assign trap_wr_q   = r_trap_q.wr;
    assign pend        = w_slot_full;
    assign overrun     = w_slot_ovr;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/trdemu_nmi_sched.md
TRDEMU_NMI_SCHED -- requirements
Module: trdemu_nmi_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, listed first: fclk (in, 1, system clock) and rst (in, 1, async active-high reset).
REQ-002 Parameter NMI_TIMEOUT SHALL default to 4095; it is the maximum fclk cycles spent in REQ.
REQ-003 Parameter HOLDOFF SHALL default to 15; it is the guard cycles after service before the next NMI.
REQ-004 Input ports SHALL be:
- trdemu_en  in  1  emulation enabled.
- trap_req  in  1  one-cycle pulse: trapped VG93 port access.
- trap_vg_a  in  2  VG register index of the trap.
- trap_wr  in  1  1 = write access, 0 = read access.
- nmi_fetch  in  1  one-cycle pulse: M1 opcode fetch from #0066.
- clr_nmi  in  1  one-cycle pulse: out (#BE),a.
- ovr_clr  in  1  clears the overrun flag.
REQ-005 Output ports SHALL be:
- gen_nmi  out  1  NMI request to the Z80 NMI driver.
- in_nmi  out  1  NMI handler active.
- trap_vg_q  out  2  latched VG index of the trap being serviced.
- trap_wr_q  out  1  latched direction of the trap being serviced.
- pend  out  1  one trap queued.
- overrun  out  1  sticky: a trap was lost.
- timeout_err  out  1  sticky: NMI was never acknowledged.

Function
REQ-006 The FSM SHALL have four states: IDLE, REQ, SERVICE, HOLDOFF.
REQ-007 In IDLE, trap_req with trdemu_en=1 SHALL latch trap_vg_q/trap_wr_q and enter REQ on the next edge; trap_req with trdemu_en=0 SHALL be ignored.
REQ-008 gen_nmi SHALL be 1 exactly while in REQ and SHALL be registered, so it rises one cycle after the accepted trap_req.
REQ-009 In REQ, a 12-bit counter SHALL clear on entry and increment every cycle.
REQ-010 nmi_fetch in REQ SHALL move the FSM to SERVICE.
REQ-011 If the REQ counter reaches NMI_TIMEOUT without nmi_fetch, the FSM SHALL go to IDLE, set timeout_err, and discard pend.
REQ-012 trdemu_en falling while in REQ SHALL abort to IDLE with no error flag set.
REQ-013 If nmi_fetch and the timeout coincide, nmi_fetch SHALL win.
REQ-014 in_nmi SHALL be 1 exactly while in SERVICE.
REQ-015 SERVICE SHALL ignore trdemu_en and nmi_fetch.
REQ-016 clr_nmi in SERVICE SHALL enter HOLDOFF; clr_nmi in any other state SHALL have no effect.
REQ-017 HOLDOFF SHALL last exactly HOLDOFF+1 cycles, counted by the same counter.
REQ-018 On HOLDOFF expiry, the FSM SHALL go to REQ if pend=1 and trdemu_en=1, loading trap_*_q from the pending slot and clearing pend.
REQ-019 On HOLDOFF expiry, the FSM SHALL go to IDLE otherwise, and pend SHALL clear.
REQ-020 A trap_req accepted in REQ, SERVICE or HOLDOFF with pend=0 SHALL fill the one-deep pending slot (index and direction) and set pend.
REQ-021 A trap_req accepted while pend=1 SHALL be dropped and SHALL set overrun.
REQ-022 trap_req coinciding with clr_nmi SHALL be queued as in REQ-020 and REQ-021.
REQ-023 trap_vg_q/trap_wr_q SHALL stay stable from REQ entry until the next REQ entry.
REQ-024 overrun SHALL clear only on ovr_clr or reset; ovr_clr coinciding with a new overrun event SHALL leave overrun=1.
REQ-025 timeout_err SHALL clear only on reset or on the next successful nmi_fetch.

Reset
REQ-026 rst asserted at any time, including mid-REQ or mid-SERVICE, SHALL immediately put the FSM in IDLE with all outputs 0, the counter 0 and the pending slot empty.
REQ-027 After rst deasserts, the first trap_req SHALL be accepted on the first fclk edge.

Structure
REQ-028 The state encoding and default NMI_TIMEOUT/HOLDOFF SHALL live in the shared trdemu package/include and be reused by the trdemu status logic.
REQ-029 The one-deep pending slot SHALL be a sub-module named trdemu_trap_slot (fill, take, full, overrun).
REQ-030 The block SHALL contain no combinational path from any input to any output.

Verification
REQ-031 trap_req (vg_a=2, wr=1) in IDLE, then nmi_fetch 10 cycles later -> gen_nmi high for cycles 1..10, in_nmi=1 from cycle 11, trap_vg_q=2, trap_wr_q=1.
REQ-032 trap_req with no nmi_fetch -> gen_nmi drops after 4096 cycles, timeout_err=1, FSM IDLE; a later successful fetch clears timeout_err.
REQ-033 In SERVICE, trap_req (vg_a=3) coinciding with clr_nmi -> pend=1; after 16 HOLDOFF cycles gen_nmi=1, trap_vg_q=3, pend=0.
REQ-034 Two trap_req pulses in SERVICE -> pend=1 and overrun=1; ovr_clr clears overrun; the first queued trap is serviced next.
REQ-035 rst pulsed mid-SERVICE with pend=1 -> all outputs 0; a subsequent trap_req is serviced normally.
REQ-036 trdemu_en cleared 5 cycles into REQ -> IDLE, gen_nmi=0, timeout_err=0, overrun=0.
